// File: rtl/tpu_link_pkg.sv
// Shared definitions for the TinyTPU serial input link: frame geometry,
// counter sizing, FSM encoding and the on-wire bit order.
package tpu_link_pkg;

    localparam int D_W_DEFAULT  = 8;
    localparam int N_DEFAULT    = 2;
    localparam int WORD_DEFAULT = 4;

    localparam int BITS_PER_VEC = N_DEFAULT * D_W_DEFAULT;

    // Element 0 goes first and each element is sent MSB first; input_control
    // reassembles with the same constant, so both ends must agree on it.
    localparam bit BIT_ORDER_ELEM0_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        INIT  = 2'd2
    } link_state_e;

    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int bit_cnt_width(input int n, input int d_w);
        return cnt_width(n * d_w);
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load shift register that emits one registered serial bit per
// shift enable, in the link's element-ordered bit sequence.
module tx_shift_reg
    import tpu_link_pkg::*;
#(
    parameter int D_W         = D_W_DEFAULT,
    parameter int N           = N_DEFAULT,
    parameter bit ELEM0_MSB_1ST = BIT_ORDER_ELEM0_MSB_FIRST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [N*D_W-1:0]   data_i,
    output logic               bit_o
);

    localparam int W = N * D_W;

    logic [W-1:0] ordered;
    logic [W-1:0] sr_q, sr_d;
    logic         bit_q, bit_d;

    // Rearrange the packed vector so the next bit to send is always the MSB.
    generate
        if (ELEM0_MSB_1ST) begin : g_elem_msb
            for (genvar i = 0; i < N; i++) begin : g_elem
                assign ordered[(N-1-i)*D_W +: D_W] = data_i[i*D_W +: D_W];
            end
        end else begin : g_lsb
            for (genvar j = 0; j < W; j++) begin : g_bit
                assign ordered[W-1-j] = data_i[j];
            end
        end
    endgenerate

    // On load the first bit goes straight to the output register and the
    // remainder waits in sr_q; the output idles at 0 between shifts.
    always_comb begin
        sr_d  = sr_q;
        bit_d = 1'b0;
        if (load_i) begin
            sr_d  = {ordered[W-2:0], 1'b0};
            bit_d = ordered[W-1];
        end else if (shift_i) begin
            sr_d  = {sr_q[W-2:0], 1'b0};
            bit_d = sr_q[W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            bit_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            bit_q <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/host_link_tx.sv
// Host-side TinyTPU link transmitter: serializes X/Y vector pairs onto the
// serial link and pulses init after every WORD-th vector.
module host_link_tx
    import tpu_link_pkg::*;
#(
    parameter int D_W  = D_W_DEFAULT,
    parameter int N    = N_DEFAULT,
    parameter int WORD = WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N*D_W-1:0]   s_x,
    input  logic [N*D_W-1:0]   s_y,
    output logic               data_in_x,
    output logic               data_in_y,
    output logic               load_en,
    output logic               init,
    output logic               busy
);

    localparam int BITS = N * D_W;
    localparam int BW   = bit_cnt_width(N, D_W);
    localparam int VW   = cnt_width(WORD);

    localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
    localparam logic [VW-1:0] VEC_LAST = VW'(WORD - 1);

    link_state_e   state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [VW-1:0] vec_cnt_q, vec_cnt_d;
    logic          load_en_q, load_en_d;
    logic          init_q, init_d;
    logic          load, shift, ready;

    // Next-state logic; the last bit cycle doubles as the accept slot so a
    // back-to-back vector starts with no bubble.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        vec_cnt_d = vec_cnt_q;
        init_d    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (s_valid) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (vec_cnt_q == VEC_LAST) begin
                        vec_cnt_d = '0;
                        init_d    = 1'b1;
                        state_d   = INIT;
                    end else begin
                        vec_cnt_d = vec_cnt_q + 1'b1;
                        ready     = 1'b1;
                        if (s_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            INIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        load_en_d = load | shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            vec_cnt_q <= '0;
            load_en_q <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            vec_cnt_q <= vec_cnt_d;
            load_en_q <= load_en_d;
            init_q    <= init_d;
        end
    end

    tx_shift_reg #(
        .D_W (D_W),
        .N   (N)
    ) u_shift_x (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (s_x),
        .bit_o   (data_in_x)
    );

    tx_shift_reg #(
        .D_W (D_W),
        .N   (N)
    ) u_shift_y (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (s_y),
        .bit_o   (data_in_y)
    );

    assign s_ready = ready & ~rst;
    assign load_en = load_en_q;
    assign init    = init_q;
    assign busy    = (state_q != IDLE) || (vec_cnt_q != '0);

    // Link-level invariants the core relies on.
    a_init_excl: assert property (@(posedge clk) disable iff (rst) !(init && load_en));
    a_idle_zero: assert property (@(posedge clk) disable iff (rst)
                                  !load_en |-> (!data_in_x && !data_in_y));

endmodule

// File: tb/tb_host_link_tx.sv
// Directed self-checking bench for host_link_tx with hand-computed bit
// sequences for the default 2x8-bit, 4-vector frame.
module tb_host_link_tx;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_x;
    logic [15:0] s_y;
    logic        data_in_x;
    logic        data_in_y;
    logic        load_en;
    logic        init;
    logic        busy;

    int errors;
    int checks;

    host_link_tx dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_x       (s_x),
        .s_y       (s_y),
        .data_in_x (data_in_x),
        .data_in_y (data_in_y),
        .load_en   (load_en),
        .init      (init),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at a falling edge, out of reset, with the DUT idle.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_vector(input logic [15:0] x, input logic [15:0] y);
        s_x     = x;
        s_y     = y;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_x     = 16'h0;
        s_y     = 16'h0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({data_in_x, data_in_y, load_en, init, busy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b want=00000",
                     {data_in_x, data_in_y, load_en, init, busy});
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready got=%b want=0", s_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle ready=%b busy=%b want ready=1 busy=0",
                     s_ready, busy);
        end
    endtask

    task automatic test_single_vector();
        logic [15:0] seq;
        seq = 16'h3CA5;
        do_reset();
        pulse_vector(16'hA53C, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (load_en !== 1'b1 || init !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_ctrl bit=%0d load_en=%b init=%b want 1/0", i, load_en, init);
            end
            checks++;
            if (data_in_x !== seq[15-i] || data_in_y !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_data bit=%0d x=%b y=%b want x=%b y=0",
                         i, data_in_x, data_in_y, seq[15-i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({load_en, init, data_in_x, data_in_y, busy, s_ready} !== 6'b000011) begin
            errors++;
            $display("[TB] FAIL single_after got=%b want=000011",
                     {load_en, init, data_in_x, data_in_y, busy, s_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seqX;
        logic [15:0] seqY;
        logic        wantReady;
        seqX = 16'h0FF0;
        seqY = 16'hF00F;
        do_reset();
        s_x     = 16'hF00F;
        s_y     = 16'h0FF0;
        s_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            wantReady = ((i % 16) == 15) && (i < 63);
            checks++;
            if (load_en !== 1'b1 || init !== 1'b0 || s_ready !== wantReady) begin
                errors++;
                $display("[TB] FAIL b2b_ctrl cycle=%0d load_en=%b init=%b ready=%b want 1/0/%b",
                         i, load_en, init, s_ready, wantReady);
            end
            checks++;
            if (data_in_x !== seqX[15-(i%16)] || data_in_y !== seqY[15-(i%16)]) begin
                errors++;
                $display("[TB] FAIL b2b_data cycle=%0d x=%b y=%b want x=%b y=%b",
                         i, data_in_x, data_in_y, seqX[15-(i%16)], seqY[15-(i%16)]);
            end
            @(negedge clk);
        end
        checks++;
        if (init !== 1'b1 || load_en !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_init init=%b load_en=%b ready=%b want 1/0/0", init, load_en, s_ready);
        end
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (init !== 1'b0 || busy !== 1'b0 || load_en !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_idle init=%b busy=%b load_en=%b ready=%b want 0/0/0/1",
                     init, busy, load_en, s_ready);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL gap_ready vec=%0d got=%b want=1", v, s_ready);
            end
            pulse_vector(16'h5A5A, 16'hC3C3);
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (load_en !== 1'b1 || init !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap_shift vec=%0d bit=%0d load_en=%b init=%b want 1/0",
                             v, i, load_en, init);
                end
                @(negedge clk);
            end
            if (v < 3) begin
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if ({load_en, init, data_in_x, data_in_y, busy} !== 5'b00001) begin
                        errors++;
                        $display("[TB] FAIL gap_idle vec=%0d gap=%0d got=%b want=00001",
                                 v, g, {load_en, init, data_in_x, data_in_y, busy});
                    end
                    @(negedge clk);
                end
            end
        end
        checks++;
        if (init !== 1'b1 || load_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_init init=%b load_en=%b want 1/0", init, load_en);
        end
        @(negedge clk);
        checks++;
        if (init !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_end init=%b busy=%b want 0/0", init, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] seqA;
        logic [15:0] seqB;
        seqA = 16'h3412;
        seqB = 16'h3CA5;
        do_reset();
        pulse_vector(16'h1234, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                s_x     = 16'hA53C;
                s_valid = 1'b1;
            end
            checks++;
            if (s_ready !== (i == 15)) begin
                errors++;
                $display("[TB] FAIL bp_ready bit=%0d got=%b want=%b", i, s_ready, (i == 15));
            end
            checks++;
            if (load_en !== 1'b1 || data_in_x !== seqA[15-i]) begin
                errors++;
                $display("[TB] FAIL bp_first bit=%0d load_en=%b x=%b want 1/%b",
                         i, load_en, data_in_x, seqA[15-i]);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (load_en !== 1'b1 || data_in_x !== seqB[15-i]) begin
                errors++;
                $display("[TB] FAIL bp_second bit=%0d load_en=%b x=%b want 1/%b",
                         i, load_en, data_in_x, seqB[15-i]);
            end
            @(negedge clk);
        end
        checks++;
        if (load_en !== 1'b0 || init !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_once load_en=%b init=%b busy=%b ready=%b want 0/0/1/1",
                     load_en, init, busy, s_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_vector(16'hFFFF, 16'hFFFF);
        repeat (16) @(negedge clk);
        pulse_vector(16'hFFFF, 16'hFFFF);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_in_x, data_in_y, load_en, init, busy, s_ready} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got=%b want=000000",
                     {data_in_x, data_in_y, load_en, init, busy, s_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        s_x     = 16'h0001;
        s_y     = 16'h0100;
        s_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (load_en !== 1'b1 || init !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_frame cycle=%0d load_en=%b init=%b want 1/0",
                         i, load_en, init);
            end
            @(negedge clk);
        end
        checks++;
        if (init !== 1'b1 || load_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_init init=%b load_en=%b want 1/0", init, load_en);
        end
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lanes();
        do_reset();
        pulse_vector(16'h0000, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (load_en !== 1'b1 || data_in_x !== 1'b0 || data_in_y !== 1'b1) begin
                errors++;
                $display("[TB] FAIL lanes bit=%0d load_en=%b x=%b y=%b want 1/0/1",
                         i, load_en, data_in_x, data_in_y);
            end
            @(negedge clk);
        end
        checks++;
        if (load_en !== 1'b0 || data_in_x !== 1'b0 || data_in_y !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lanes_after load_en=%b x=%b y=%b want 0/0/0",
                     load_en, data_in_x, data_in_y);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_lanes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
